dmem_resp: RTL and testbench

Data-side memory responder at the far end of the EX-stage data SRAM request port: it accepts the single-cycle enable/byte-write/address/data request the EX stage issues, and returns read data one cycle later for the MEM stage. It decodes a 32-bit address space into three regions: on-chip data RAM, a small machine-timer MMIO block (mtime/mtimecmp/scratch), and an unmapped region. It drives the timer interrupt line to the CSR logic.

---
 rtl/dmem_resp.sv | 164 ++++++++++++++++
 tb/tb_dmem_resp.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: data-side memory responder for the EX-stage data SRAM port.
//
// Accepts one single-cycle request per clock (no backpressure) and returns
// registered read data one cycle later. The 32-bit byte address space is
// decoded into three regions:
//   - on-chip data RAM   : addr[31:ADDR_W+2] == 0
//   - machine-timer MMIO : addr[31:8] == MMIO_BASE[31:8]
//                          0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo,
//                          0x0C mtimecmp_hi, 0x10 scratch; other offsets
//                          read 0 and ignore writes
//   - unmapped           : everything else (read -> 0, write dropped,
//                          one-cycle bus_err pulse)
//
// Ports:
//   clk                in   clock, all state on rising edge
//   rst_n              in   synchronous active-low reset
//   data_sram_en_i     in   request valid
//   data_sram_we_i     in   [3:0] byte write enables, 0 = read
//   data_sram_addr_i   in   [31:0] byte address, bits [1:0] ignored
//   data_sram_wdata_i  in   [31:0] lane-aligned write data
//   data_sram_rdata_o  out  [31:0] registered read data (full word)
//   timer_irq_o        out  registered (mtime >= mtimecmp)
//   bus_err_o          out  one-cycle pulse after an unmapped access
module dmem_resp #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_sram_en_i,
  input  logic [3:0]  data_sram_we_i,
  input  logic [31:0] data_sram_addr_i,
  input  logic [31:0] data_sram_wdata_i,
  output logic [31:0] data_sram_rdata_o,
  output logic        timer_irq_o,
  output logic        bus_err_o
);

  localparam int unsigned Words = 1 << ADDR_W;

  localparam logic [5:0] OffMtimeLo = 6'h00;
  localparam logic [5:0] OffMtimeHi = 6'h01;
  localparam logic [5:0] OffCmpLo   = 6'h02;
  localparam logic [5:0] OffCmpHi   = 6'h03;
  localparam logic [5:0] OffScratch = 6'h04;

  // Byte-lane merge: lanes with we[i] set take the new byte.
  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] new_word,
                                        input logic [3:0]  we);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0] mem [Words];

  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        irq_q, irq_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] scratch_q, scratch_d;

  logic              ram_sel, mmio_sel, unmapped;
  logic              rd_req, wr_req;
  logic [ADDR_W-1:0] ram_idx;
  logic [5:0]        mmio_off;
  logic [31:0]       mmio_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^data_sram_addr_i[1:0];

  // Request decode
  always_comb begin
    ram_sel  = (data_sram_addr_i[31:ADDR_W+2] == '0);
    mmio_sel = !ram_sel && (data_sram_addr_i[31:8] == MMIO_BASE[31:8]);
    unmapped = !ram_sel && !mmio_sel;
    rd_req   = data_sram_en_i && (data_sram_we_i == 4'h0);
    wr_req   = data_sram_en_i && (data_sram_we_i != 4'h0);
    ram_idx  = data_sram_addr_i[ADDR_W+1:2];
    mmio_off = data_sram_addr_i[7:2];
  end

  // MMIO read mux: register values before this cycle's update
  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_off)
      OffMtimeLo: mmio_rdata = mtime_q[31:0];
      OffMtimeHi: mmio_rdata = mtime_q[63:32];
      OffCmpLo:   mmio_rdata = mtimecmp_q[31:0];
      OffCmpHi:   mmio_rdata = mtimecmp_q[63:32];
      OffScratch: mmio_rdata = scratch_q;
      default:    mmio_rdata = 32'h0;
    endcase
  end

  // Next-state for read path, error pulse and MMIO registers
  always_comb begin
    rdata_d    = rdata_q;
    bus_err_d  = data_sram_en_i && unmapped;
    irq_d      = (mtime_q >= mtimecmp_q);
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    scratch_d  = scratch_q;

    if (rd_req) begin
      if (ram_sel)       rdata_d = mem[ram_idx];
      else if (mmio_sel) rdata_d = mmio_rdata;
      else               rdata_d = 32'h0;
    end

    // A write to either mtime half replaces the whole increment that cycle.
    if (wr_req && mmio_sel) begin
      case (mmio_off)
        OffMtimeLo: mtime_d = {mtime_q[63:32],
                               merge(mtime_q[31:0], data_sram_wdata_i, data_sram_we_i)};
        OffMtimeHi: mtime_d = {merge(mtime_q[63:32], data_sram_wdata_i, data_sram_we_i),
                               mtime_q[31:0]};
        OffCmpLo:   mtimecmp_d[31:0] =
                        merge(mtimecmp_q[31:0], data_sram_wdata_i, data_sram_we_i);
        OffCmpHi:   mtimecmp_d[63:32] =
                        merge(mtimecmp_q[63:32], data_sram_wdata_i, data_sram_we_i);
        OffScratch: scratch_d = merge(scratch_q, data_sram_wdata_i, data_sram_we_i);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q    <= 32'h0;
      bus_err_q  <= 1'b0;
      irq_q      <= 1'b0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      scratch_q  <= 32'h0;
    end else begin
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      irq_q      <= irq_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      scratch_q  <= scratch_d;
    end
  end

  // RAM array is not reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wr_req && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we_i[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata_i[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata_o = rdata_q;
  assign timer_irq_o       = irq_q;
  assign bus_err_o         = bus_err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed testbench for dmem_resp. Inputs change 1 ns after a rising edge;
// outputs are sampled at the same point, so each cyc() call leaves the bench
// just after the edge that consumed its request.
module tb_dmem_resp;

  localparam logic [31:0] MtLo   = 32'h1000_0000;
  localparam logic [31:0] MtHi   = 32'h1000_0004;
  localparam logic [31:0] CmpLo  = 32'h1000_0008;
  localparam logic [31:0] CmpHi  = 32'h1000_000C;
  localparam logic [31:0] Scr    = 32'h1000_0010;
  localparam logic [31:0] MmHole = 32'h1000_0040;
  localparam logic [31:0] Unmap  = 32'h2000_0000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        berr;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_resp #(
    .ADDR_W    (14),
    .MMIO_BASE (32'h1000_0000)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .data_sram_en_i    (en),
    .data_sram_we_i    (we),
    .data_sram_addr_i  (addr),
    .data_sram_wdata_i (wdata),
    .data_sram_rdata_o (rdata),
    .timer_irq_o       (irq),
    .bus_err_o         (berr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request cycle; returns 1 ns after the consuming edge.
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    en    = e;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    en    = 1'b0;
    we    = 4'h0;
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    we    = 4'h0;
    addr  = 32'h0;
    wdata = 32'h0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_berr", {31'h0, berr}, 32'h0);
    rst_n = 1'b1;
    cyc(1'b1, 4'h0, MtLo, 32'h0);
    chk("first_mtime_lo", rdata, 32'h0);

    // Byte-lane RAM writes; rdata holds through write cycles
    cyc(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    chk("wr1_rdata_hold", rdata, 32'h0);
    cyc(1'b1, 4'h2, 32'h100, 32'h0000_5500);
    chk("wr2_rdata_hold", rdata, 32'h0);
    cyc(1'b1, 4'h0, 32'h100, 32'h0);
    chk("ram_lane_merge", rdata, 32'hDEAD_55EF);
    chk("ram_rd_berr", {31'h0, berr}, 32'h0);
    idle();
    chk("idle_hold", rdata, 32'hDEAD_55EF);

    // Back-to-back write then read
    cyc(1'b1, 4'hF, 32'h204, 32'h1234_5678);
    cyc(1'b1, 4'h0, 32'h204, 32'h0);
    chk("b2b_read", rdata, 32'h1234_5678);

    // Scratch with byte lanes
    cyc(1'b1, 4'hF, Scr, 32'hA5A5_A5A5);
    cyc(1'b1, 4'h2, Scr, 32'h0000_3C00);
    cyc(1'b1, 4'h0, Scr, 32'h0);
    chk("scratch_lane", rdata, 32'hA5A5_3CA5);

    // Timer interrupt: mtime=0 after edge W, reaches 20 after W+20,
    // so irq is high from W+21 on.
    cyc(1'b1, 4'hF, CmpHi, 32'h0);
    cyc(1'b1, 4'hF, CmpLo, 32'd20);
    cyc(1'b1, 4'hF, MtHi, 32'h0);
    cyc(1'b1, 4'hF, MtLo, 32'h0);
    for (int k = 1; k <= 25; k++) begin
      idle();
      chk($sformatf("irq_k%0d", k), {31'h0, irq}, {31'h0, (k >= 21)});
    end
    cyc(1'b1, 4'hF, CmpHi, 32'h1);
    idle();
    chk("irq_drop_1", {31'h0, irq}, 32'h0);
    idle();
    chk("irq_drop_2", {31'h0, irq}, 32'h0);
    cyc(1'b1, 4'h0, CmpHi, 32'h0);
    chk("cmp_hi_rd", rdata, 32'h1);
    cyc(1'b1, 4'h0, CmpLo, 32'h0);
    chk("cmp_lo_rd", rdata, 32'd20);

    // Carry: {0,FFFFFFFF} after B, {1,0} after B+1, {1,1} after B+2
    cyc(1'b1, 4'hF, MtHi, 32'h0);
    cyc(1'b1, 4'hF, MtLo, 32'hFFFF_FFFF);
    idle();
    cyc(1'b1, 4'h0, MtLo, 32'h0);
    chk("carry_lo", rdata, 32'h0);
    cyc(1'b1, 4'h0, MtHi, 32'h0);
    chk("carry_hi", rdata, 32'h1);

    // Wrap: all-ones after D, 0 after D+1, 1 after D+2
    cyc(1'b1, 4'hF, MtHi, 32'hFFFF_FFFF);
    cyc(1'b1, 4'hF, MtLo, 32'hFFFF_FFFF);
    cyc(1'b1, 4'h0, MtLo, 32'h0);
    chk("wrap_pre_lo", rdata, 32'hFFFF_FFFF);
    cyc(1'b1, 4'h0, MtHi, 32'h0);
    chk("wrap_hi", rdata, 32'h0);
    cyc(1'b1, 4'h0, MtLo, 32'h0);
    chk("wrap_lo", rdata, 32'h1);

    // Unmapped accesses
    cyc(1'b1, 4'hF, 32'h000, 32'hCAFE_F00D);
    cyc(1'b1, 4'h0, 32'h204, 32'h0);
    cyc(1'b1, 4'hF, Unmap, 32'h1111_1111);
    chk("unm_wr_berr", {31'h0, berr}, 32'h1);
    chk("unm_wr_rdata", rdata, 32'h1234_5678);
    idle();
    chk("unm_wr_berr_end", {31'h0, berr}, 32'h0);
    cyc(1'b1, 4'h0, 32'h000, 32'h0);
    chk("unm_wr_ram_kept", rdata, 32'hCAFE_F00D);
    cyc(1'b1, 4'hF, Unmap + 32'h10, 32'h2222_2222);
    chk("unm_wr2_berr", {31'h0, berr}, 32'h1);
    cyc(1'b1, 4'h0, Scr, 32'h0);
    chk("unm_wr_scr_kept", rdata, 32'hA5A5_3CA5);
    chk("scr_rd_berr", {31'h0, berr}, 32'h0);
    cyc(1'b1, 4'h0, Unmap, 32'h0);
    chk("unm_rd_rdata", rdata, 32'h0);
    chk("unm_rd_berr", {31'h0, berr}, 32'h1);
    idle();
    chk("unm_rd_berr_end", {31'h0, berr}, 32'h0);

    // Unused MMIO offset: reads 0, write ignored, no error
    cyc(1'b1, 4'h0, 32'h204, 32'h0);
    cyc(1'b1, 4'hF, MmHole, 32'hFFFF_FFFF);
    chk("hole_wr_berr", {31'h0, berr}, 32'h0);
    cyc(1'b1, 4'h0, MmHole, 32'h0);
    chk("hole_rd_rdata", rdata, 32'h0);
    chk("hole_rd_berr", {31'h0, berr}, 32'h0);

    // Reset mid-operation
    cyc(1'b1, 4'h0, 32'h204, 32'h0);
    chk("pre_rst_rd", rdata, 32'h1234_5678);
    rst_n = 1'b0;
    cyc(1'b1, 4'h0, 32'h100, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    cyc(1'b1, 4'hF, 32'h100, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    cyc(1'b1, 4'h0, 32'h100, 32'h0);
    chk("rst_wr_ignored", rdata, 32'hDEAD_55EF);
    cyc(1'b1, 4'h0, Scr, 32'h0);
    chk("rst_scratch", rdata, 32'h0);
    cyc(1'b1, 4'h0, CmpLo, 32'h0);
    chk("rst_cmp_lo", rdata, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
